rv_hazard_ctrl: RTL and testbench

- Pipeline hazard controller for the RV core; it sequences the execute datapath.
- Generates per-operand bypass selects for the execute stage.
- Generates fetch/decode stall, fetch→decode and decode→execute flushes, and, optionally, the ALU stage-2 flush.
- Owns the load-use stall and branch-redirect sequencing via a small FSM with counters.

---
 rtl/rv_hazard_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_rv_hazard_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_hazard_ctrl.sv
// rv_hazard_ctrl: pipeline hazard controller for the RV core.
// Produces execute-stage operand bypass selects, fetch/decode stalls and
// pipeline flushes, and sequences init, load-use and redirect cycles.
// Optional build macro RV_HAZARD_ALU2_EN adds ALU stage-1 load-use checking
// and the stage-2 flush output for the two-stage ALU.
// Control outputs react to inputs in the same cycle, so they are
// combinational functions of the state register and the hazard inputs.

module rv_hazard_ctrl #(
  parameter int unsigned INIT_CYCLES  = 2,
  parameter int unsigned LU_CYCLES    = 1,
  parameter int unsigned REDIR_CYCLES = 1
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic [4:0] i_dec_rs1,
  input  logic [4:0] i_dec_rs2,
  input  logic [4:0] i_ex_rs1,
  input  logic [4:0] i_ex_rs2,
  input  logic [4:0] i_ex_rd,
  input  logic       i_ex_mem_read,
  input  logic       i_pc_src,
  input  logic [4:0] i_mem_rd,
  input  logic       i_mem_reg_write,
  input  logic [4:0] i_wr_rd,
  input  logic       i_wr_reg_write,
  input  logic [4:0] i_wb_rd,
  input  logic       i_wb_reg_write,
`ifdef RV_HAZARD_ALU2_EN
  input  logic [4:0] i_st1_rd,
  input  logic       i_st1_mem_read,
`endif
  output logic [1:0] o_bp_rs1,
  output logic [1:0] o_bp_rs2,
  output logic       o_fetch_stall,
  output logic       o_dec_stall,
  output logic       o_fd_flush,
  output logic       o_de_flush,
`ifdef RV_HAZARD_ALU2_EN
  output logic       o_st2_flush,
`endif
  output logic [1:0] o_state
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned REG_W = 5;

  localparam logic [CNT_W-1:0] INIT_LOAD  = CNT_W'(INIT_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] LU_LOAD    = CNT_W'((LU_CYCLES > 32'd1) ? (LU_CYCLES - 32'd2) : 32'd0);
  localparam logic [CNT_W-1:0] REDIR_LOAD = CNT_W'((REDIR_CYCLES > 32'd1) ? (REDIR_CYCLES - 32'd2) : 32'd0);
  localparam logic             LU_MULTI    = (LU_CYCLES > 32'd1);
  localparam logic             REDIR_MULTI = (REDIR_CYCLES > 32'd1);
`ifdef RV_HAZARD_ALU2_EN
  localparam logic [CNT_W-1:0] ST1_LOAD   = CNT_W'(LU_CYCLES - 32'd1);
`endif

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_LU    = 2'd2,
    ST_REDIR = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic fetch_stall_c, dec_stall_c, fd_flush_c, de_flush_c, st2_flush_c;
  logic lu_ex_c, lu_st1_c;
  logic [1:0] bp_rs1_c, bp_rs2_c;

  // Nearest producing stage wins; x0 and non-writing stages never forward.
  function automatic logic [1:0] bp_sel(
    input logic [REG_W-1:0] rs,
    input logic [REG_W-1:0] mem_rd, input logic mem_we,
    input logic [REG_W-1:0] wr_rd,  input logic wr_we,
    input logic [REG_W-1:0] wb_rd,  input logic wb_we
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (rs != '0) begin
      if (mem_we && (mem_rd == rs))     sel = 2'b01;
      else if (wr_we && (wr_rd == rs))  sel = 2'b10;
      else if (wb_we && (wb_rd == rs))  sel = 2'b11;
    end
    return sel;
  endfunction

  // Operand bypass selects; held at regfile while reset is asserted.
  always_comb begin
    bp_rs1_c = 2'b00;
    bp_rs2_c = 2'b00;
    if (i_reset_n) begin
      bp_rs1_c = bp_sel(i_ex_rs1, i_mem_rd, i_mem_reg_write, i_wr_rd, i_wr_reg_write,
                        i_wb_rd, i_wb_reg_write);
      bp_rs2_c = bp_sel(i_ex_rs2, i_mem_rd, i_mem_reg_write, i_wr_rd, i_wr_reg_write,
                        i_wb_rd, i_wb_reg_write);
    end
  end

  // Load-use detection against the execute (and optionally ALU stage-1) load.
  always_comb begin
    lu_ex_c  = i_ex_mem_read && (i_ex_rd != '0) &&
               ((i_ex_rd == i_dec_rs1) || (i_ex_rd == i_dec_rs2));
`ifdef RV_HAZARD_ALU2_EN
    lu_st1_c = i_st1_mem_read && (i_st1_rd != '0) &&
               ((i_st1_rd == i_dec_rs1) || (i_st1_rd == i_dec_rs2));
`else
    lu_st1_c = 1'b0;
`endif
  end

  // Next-state, counter and control-output logic.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    fetch_stall_c = 1'b0;
    dec_stall_c   = 1'b0;
    fd_flush_c    = 1'b0;
    de_flush_c    = 1'b0;
    st2_flush_c   = 1'b0;
    unique case (state_q)
      ST_INIT: begin
        fetch_stall_c = 1'b1;
        dec_stall_c   = 1'b1;
        fd_flush_c    = 1'b1;
        de_flush_c    = 1'b1;
        st2_flush_c   = 1'b1;
        if (cnt_q == '0) state_d = ST_RUN;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_RUN, ST_LU: begin
        if (i_pc_src) begin
          // Redirect outranks load-use and aborts any bubble sequence.
          fd_flush_c  = 1'b1;
          de_flush_c  = 1'b1;
          st2_flush_c = 1'b1;
          if (REDIR_MULTI) begin
            state_d = ST_REDIR;
            cnt_d   = REDIR_LOAD;
          end else begin
            state_d = ST_RUN;
          end
        end else if (state_q == ST_LU) begin
          fetch_stall_c = 1'b1;
          dec_stall_c   = 1'b1;
          de_flush_c    = 1'b1;
          if (cnt_q == '0) state_d = ST_RUN;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end else if (lu_st1_c || lu_ex_c) begin
          fetch_stall_c = 1'b1;
          dec_stall_c   = 1'b1;
          de_flush_c    = 1'b1;
`ifdef RV_HAZARD_ALU2_EN
          if (lu_st1_c) begin
            // Stage-1 producer is one stage further back: one extra bubble.
            state_d = ST_LU;
            cnt_d   = ST1_LOAD;
          end else
`endif
          if (LU_MULTI) begin
            state_d = ST_LU;
            cnt_d   = LU_LOAD;
          end
        end
      end
      ST_REDIR: begin
        fd_flush_c = 1'b1;
        if (i_pc_src) begin
          // A fresh redirect also kills decode and restarts the hold window.
          de_flush_c  = 1'b1;
          st2_flush_c = 1'b1;
          cnt_d       = REDIR_LOAD;
        end else if (cnt_q == '0) begin
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  // State and counter registers; reset reloads the init window.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= ST_INIT;
      cnt_q   <= INIT_LOAD;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_bp_rs1      = bp_rs1_c;
  assign o_bp_rs2      = bp_rs2_c;
  assign o_fetch_stall = fetch_stall_c;
  assign o_dec_stall   = dec_stall_c;
  assign o_fd_flush    = fd_flush_c;
  assign o_de_flush    = de_flush_c;
  assign o_state       = state_q;
`ifdef RV_HAZARD_ALU2_EN
  assign o_st2_flush   = st2_flush_c;
`else
  logic unused_st2;
  assign unused_st2 = st2_flush_c;
`endif

endmodule

// File: tb/tb_rv_hazard_ctrl.sv
// Directed bench for rv_hazard_ctrl: two instances with different bubble and
// redirect lengths share one stimulus stream; expected outputs are queued
// with each step and checked shortly after the inputs settle.

module tb_rv_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] dec_rs1, dec_rs2, ex_rs1, ex_rs2, ex_rd;
  logic       ex_mem_read, pc_src;
  logic [4:0] mem_rd, wr_rd, wb_rd;
  logic       mem_we, wr_we, wb_we;
  logic [4:0] st1_rd;
  logic       st1_mem_read;

  logic [1:0] a_bp1, a_bp2, b_bp1, b_bp2, a_state, b_state;
  logic       a_fs, a_ds, a_fd, a_de, b_fs, b_ds, b_fd, b_de;
  logic       a_st2, b_st2;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [3:0] C_IDLE = 4'b0000;
  localparam logic [3:0] C_ALL  = 4'b1111;
  localparam logic [3:0] C_LU   = 4'b1101;
  localparam logic [3:0] C_RD   = 4'b0011;
  localparam logic [3:0] C_FD   = 4'b0010;

  typedef struct {
    string      tag;
    logic [5:0] a;
    logic [5:0] b;
    logic [3:0] bp;
    logic [1:0] st2;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  rv_hazard_ctrl #(.INIT_CYCLES(2), .LU_CYCLES(1), .REDIR_CYCLES(2)) u_dut_a (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_dec_rs1(dec_rs1), .i_dec_rs2(dec_rs2),
    .i_ex_rs1(ex_rs1), .i_ex_rs2(ex_rs2), .i_ex_rd(ex_rd),
    .i_ex_mem_read(ex_mem_read), .i_pc_src(pc_src),
    .i_mem_rd(mem_rd), .i_mem_reg_write(mem_we),
    .i_wr_rd(wr_rd), .i_wr_reg_write(wr_we),
    .i_wb_rd(wb_rd), .i_wb_reg_write(wb_we),
`ifdef RV_HAZARD_ALU2_EN
    .i_st1_rd(st1_rd), .i_st1_mem_read(st1_mem_read),
    .o_st2_flush(a_st2),
`endif
    .o_bp_rs1(a_bp1), .o_bp_rs2(a_bp2),
    .o_fetch_stall(a_fs), .o_dec_stall(a_ds),
    .o_fd_flush(a_fd), .o_de_flush(a_de),
    .o_state(a_state)
  );

  rv_hazard_ctrl #(.INIT_CYCLES(2), .LU_CYCLES(3), .REDIR_CYCLES(1)) u_dut_b (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_dec_rs1(dec_rs1), .i_dec_rs2(dec_rs2),
    .i_ex_rs1(ex_rs1), .i_ex_rs2(ex_rs2), .i_ex_rd(ex_rd),
    .i_ex_mem_read(ex_mem_read), .i_pc_src(pc_src),
    .i_mem_rd(mem_rd), .i_mem_reg_write(mem_we),
    .i_wr_rd(wr_rd), .i_wr_reg_write(wr_we),
    .i_wb_rd(wb_rd), .i_wb_reg_write(wb_we),
`ifdef RV_HAZARD_ALU2_EN
    .i_st1_rd(st1_rd), .i_st1_mem_read(st1_mem_read),
    .o_st2_flush(b_st2),
`endif
    .o_bp_rs1(b_bp1), .o_bp_rs2(b_bp2),
    .o_fetch_stall(b_fs), .o_dec_stall(b_ds),
    .o_fd_flush(b_fd), .o_de_flush(b_de),
    .o_state(b_state)
  );

`ifndef RV_HAZARD_ALU2_EN
  assign a_st2 = 1'b0;
  assign b_st2 = 1'b0;
`endif

  task automatic clr_inputs();
    dec_rs1 = '0; dec_rs2 = '0; ex_rs1 = '0; ex_rs2 = '0; ex_rd = '0;
    ex_mem_read = 1'b0; pc_src = 1'b0;
    mem_rd = '0; wr_rd = '0; wb_rd = '0;
    mem_we = 1'b0; wr_we = 1'b0; wb_we = 1'b0;
    st1_rd = '0; st1_mem_read = 1'b0;
  endtask

  task automatic set_load_use();
    ex_mem_read = 1'b1; ex_rd = 5'd7; dec_rs2 = 5'd7;
  endtask

  // Pop the oldest expectation and compare it with the settled outputs.
  task automatic check_front();
    exp_t e;
    logic [5:0] obs_a, obs_b;
    logic [3:0] obs_bp;
    e      = sb_q.pop_front();
    obs_a  = {a_state, a_fs, a_ds, a_fd, a_de};
    obs_b  = {b_state, b_fs, b_ds, b_fd, b_de};
    obs_bp = {a_bp1, a_bp2};
    n_tests++;
    assert (obs_a === e.a) else begin
      n_fail++;
      $error("FAIL %s dut_a state/ctrl observed=%b expected=%b", e.tag, obs_a, e.a);
    end
    n_tests++;
    assert (obs_b === e.b) else begin
      n_fail++;
      $error("FAIL %s dut_b state/ctrl observed=%b expected=%b", e.tag, obs_b, e.b);
    end
    n_tests++;
    assert ({obs_bp, b_bp1, b_bp2} === {e.bp, e.bp}) else begin
      n_fail++;
      $error("FAIL %s bypass observed=%b/%b expected=%b", e.tag, obs_bp, {b_bp1, b_bp2}, e.bp);
    end
`ifdef RV_HAZARD_ALU2_EN
    n_tests++;
    assert ({a_st2, b_st2} === e.st2) else begin
      n_fail++;
      $error("FAIL %s st2_flush observed=%b expected=%b", e.tag, {a_st2, b_st2}, e.st2);
    end
`endif
  endtask

  task automatic expect_now(input string tag, input logic [5:0] ea, input logic [5:0] eb,
                            input logic [3:0] ebp, input logic [1:0] est2);
    exp_t e;
    e.tag = tag; e.a = ea; e.b = eb; e.bp = ebp; e.st2 = est2;
    sb_q.push_back(e);
    #1;
    check_front();
  endtask

  task automatic next_cycle();
    @(negedge clk);
    clr_inputs();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset: controls forced high, bypass held at regfile even with a match.
    clr_inputs();
    rst_n = 1'b0;
    ex_rs1 = 5'd5; mem_rd = 5'd5; mem_we = 1'b1;
    expect_now("reset_hold", {2'd0, C_ALL}, {2'd0, C_ALL}, 4'b0000, 2'b11);

    next_cycle(); rst_n = 1'b1;
    expect_now("init_c1", {2'd0, C_ALL}, {2'd0, C_ALL}, 4'b0000, 2'b11);
    next_cycle(); pc_src = 1'b1;
    expect_now("init_c2_pcsrc_ignored", {2'd0, C_ALL}, {2'd0, C_ALL}, 4'b0000, 2'b11);
    next_cycle();
    expect_now("run_entry", {2'd1, C_IDLE}, {2'd1, C_IDLE}, 4'b0000, 2'b00);

    // Bypass priority and gating.
    next_cycle(); ex_rs1 = 5'd5; mem_rd = 5'd5; mem_we = 1'b1; wr_rd = 5'd5; wr_we = 1'b1;
    expect_now("bp_mem_wins", {2'd1, C_IDLE}, {2'd1, C_IDLE}, 4'b0100, 2'b00);
    next_cycle(); ex_rs1 = 5'd5; mem_rd = 5'd5; wr_rd = 5'd5; wr_we = 1'b1;
    ex_rs2 = 5'd9; wb_rd = 5'd9; wb_we = 1'b1;
    expect_now("bp_wr_and_wb", {2'd1, C_IDLE}, {2'd1, C_IDLE}, 4'b1011, 2'b00);
    next_cycle(); ex_rs2 = 5'd3; mem_we = 1'b1; wr_we = 1'b1; wb_we = 1'b1;
    expect_now("bp_x0", {2'd1, C_IDLE}, {2'd1, C_IDLE}, 4'b0000, 2'b00);
    next_cycle(); ex_rs1 = 5'd4; ex_rs2 = 5'd4; mem_rd = 5'd4; wr_rd = 5'd4;
    wb_rd = 5'd4; wb_we = 1'b1;
    expect_now("bp_we_gate", {2'd1, C_IDLE}, {2'd1, C_IDLE}, 4'b1111, 2'b00);

    // Load-use qualifiers and bubble lengths.
    next_cycle(); ex_mem_read = 1'b1;
    expect_now("lu_rd0_none", {2'd1, C_IDLE}, {2'd1, C_IDLE}, 4'b0000, 2'b00);
    next_cycle(); ex_rd = 5'd7; dec_rs1 = 5'd7;
    expect_now("lu_noload_none", {2'd1, C_IDLE}, {2'd1, C_IDLE}, 4'b0000, 2'b00);
    next_cycle(); set_load_use();
    expect_now("lu_detect", {2'd1, C_LU}, {2'd1, C_LU}, 4'b0000, 2'b00);
    next_cycle();
    expect_now("lu_c2", {2'd1, C_IDLE}, {2'd2, C_LU}, 4'b0000, 2'b00);
    next_cycle();
    expect_now("lu_c3", {2'd1, C_IDLE}, {2'd2, C_LU}, 4'b0000, 2'b00);
    next_cycle();
    expect_now("lu_done", {2'd1, C_IDLE}, {2'd1, C_IDLE}, 4'b0000, 2'b00);

    // Redirect hold window.
    next_cycle(); pc_src = 1'b1;
    expect_now("redir_c0", {2'd1, C_RD}, {2'd1, C_RD}, 4'b0000, 2'b11);
    next_cycle();
    expect_now("redir_c1", {2'd3, C_FD}, {2'd1, C_IDLE}, 4'b0000, 2'b00);
    next_cycle();
    expect_now("redir_done", {2'd1, C_IDLE}, {2'd1, C_IDLE}, 4'b0000, 2'b00);

    // Redirect beats a simultaneous load-use.
    next_cycle(); pc_src = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd7; dec_rs1 = 5'd7;
    expect_now("redir_lu_same", {2'd1, C_RD}, {2'd1, C_RD}, 4'b0000, 2'b11);
    next_cycle();
    expect_now("redir_lu_c1", {2'd3, C_FD}, {2'd1, C_IDLE}, 4'b0000, 2'b00);

    // Redirect inside the hold window restarts it.
    next_cycle(); pc_src = 1'b1;
    expect_now("redir_again_c0", {2'd1, C_RD}, {2'd1, C_RD}, 4'b0000, 2'b11);
    next_cycle(); pc_src = 1'b1;
    expect_now("redir_restart", {2'd3, C_RD}, {2'd1, C_RD}, 4'b0000, 2'b11);
    next_cycle();
    expect_now("redir_restart_c1", {2'd3, C_FD}, {2'd1, C_IDLE}, 4'b0000, 2'b00);
    next_cycle();
    expect_now("redir_restart_done", {2'd1, C_IDLE}, {2'd1, C_IDLE}, 4'b0000, 2'b00);

    // Redirect aborts an in-progress bubble sequence.
    next_cycle(); set_load_use();
    expect_now("lu2_detect", {2'd1, C_LU}, {2'd1, C_LU}, 4'b0000, 2'b00);
    next_cycle(); pc_src = 1'b1;
    expect_now("lu_abort", {2'd1, C_RD}, {2'd2, C_RD}, 4'b0000, 2'b11);
    next_cycle();
    expect_now("lu_abort_c1", {2'd3, C_FD}, {2'd1, C_IDLE}, 4'b0000, 2'b00);

    // Asynchronous reset in the middle of a bubble sequence.
    next_cycle(); set_load_use();
    expect_now("lu3_detect", {2'd1, C_LU}, {2'd1, C_LU}, 4'b0000, 2'b00);
    next_cycle();
    expect_now("lu3_c2", {2'd1, C_IDLE}, {2'd2, C_LU}, 4'b0000, 2'b00);
    #1 rst_n = 1'b0;
    expect_now("reset_in_lu", {2'd0, C_ALL}, {2'd0, C_ALL}, 4'b0000, 2'b11);
    next_cycle(); rst_n = 1'b1;
    expect_now("reinit_c1", {2'd0, C_ALL}, {2'd0, C_ALL}, 4'b0000, 2'b11);
    next_cycle();
    expect_now("reinit_c2", {2'd0, C_ALL}, {2'd0, C_ALL}, 4'b0000, 2'b11);
    next_cycle();
    expect_now("reinit_run", {2'd1, C_IDLE}, {2'd1, C_IDLE}, 4'b0000, 2'b00);

`ifdef RV_HAZARD_ALU2_EN
    // Stage-1 load hit adds one bubble over the execute-stage case.
    next_cycle(); st1_mem_read = 1'b1; st1_rd = 5'd7; dec_rs1 = 5'd7;
    expect_now("st1_detect", {2'd1, C_LU}, {2'd1, C_LU}, 4'b0000, 2'b00);
    next_cycle();
    expect_now("st1_c2", {2'd2, C_LU}, {2'd2, C_LU}, 4'b0000, 2'b00);
    next_cycle();
    expect_now("st1_c3", {2'd1, C_IDLE}, {2'd2, C_LU}, 4'b0000, 2'b00);
    next_cycle();
    expect_now("st1_c4", {2'd1, C_IDLE}, {2'd2, C_LU}, 4'b0000, 2'b00);
    next_cycle();
    expect_now("st1_c5", {2'd1, C_IDLE}, {2'd1, C_IDLE}, 4'b0000, 2'b00);
`endif

    next_cycle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
